nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
//
// PURPOSE
//   Sequencer that reuses one adder_4bit instance to add two WIDTH-bit operands, one nibble per cycle, LSB nibble first.
//   The nibble carry is kept in a register between cycles.
//   The block accepts an operation through a valid/ready start handshake and holds the result until a valid/ready result handshake completes.
//   It sits between a requesting control unit and the shared 4-bit adder datapath.
//
// PARAMETERS
//   WIDTH        16   operand/sum width in bits; multiple of 4, >= 4
//   NUM_NIBBLES  WIDTH/4  derived localparam; number of ADD cycles
//
// PORTS
//   clk           in   1      system clock; all state changes on rising edge
//   rst           in   1      synchronous, active-high reset
//   start_valid   in   1      requester presents an operation
//   start_ready   out  1      block can accept an operation (high only in IDLE)
//   op_a          in   WIDTH  operand A, sampled on the start handshake
//   op_b          in   WIDTH  operand B, sampled on the start handshake
//   carry_in      in   1      carry into nibble 0, sampled on the start handshake
//   result_valid  out  1      sum/carry_out are valid (high only in DONE)
//   result_ready  in   1      consumer accepts the result
//   sum           out  WIDTH  registered sum (op_a + op_b + carry_in) mod 2^WIDTH
//   carry_out     out  1      bit WIDTH of op_a + op_b + carry_in
//   busy          out  1      high in ADD or DONE
//
// BEHAVIOUR
//   - Clocking/reset: one clock, clk. Reset rst is synchronous and active-high.
//   - Values while rst is high and on the first cycle after it:
//       state=IDLE; a_sh, b_sh, sum, carry reg and count all 0.
//       start_ready=1, result_valid=0, busy=0, sum=0, carry_out=0.
//   - Start handshake: completes on a rising edge where start_valid && start_ready.
//       Latches op_a, op_b, carry_in; clears count; state moves IDLE->ADD.
//   - ADD state, every cycle:
//       The adder_4bit inputs are a_sh[3:0], b_sh[3:0] and the carry reg.
//       On the clock edge, sum shifts right 4 and the nibble sum enters at sum[WIDTH-1:WIDTH-4].
//       a_sh and b_sh shift right 4 with zero fill.
//       The carry reg loads the adder overflow; count increments.
//   - ADD->DONE on the edge where count == NUM_NIBBLES-1.
//       On that same edge carry_out loads the final overflow.
//   - Latency: result_valid rises exactly NUM_NIBBLES cycles after the start-handshake edge (WIDTH=16 -> 4 cycles).
//   - DONE state:
//       result_valid=1; sum and carry_out are held stable.
//       Leaves for IDLE on the edge where result_ready=1; result_valid is 0 the next cycle.
//       Minimum start-to-start spacing is NUM_NIBBLES+1 cycles.
//   - start_ready is a combinational decode of state==IDLE.
//       start_valid during ADD or DONE is ignored; no queuing, no operand change.
//   - Operands changing after the handshake have no effect.
//   - sum/carry_out keep their last value in IDLE until the next operation starts overwriting them.
//   - rst high in any state aborts the operation: IDLE next cycle, all registers cleared, no result_valid pulse.
//   - result_ready held high before DONE: DONE lasts exactly one cycle.
//   - WIDTH=4: one ADD cycle; the carry reg is used only for carry_in.
//   - Illegal state encodings decode to IDLE.
//
// STRUCTURE
//   - Package nibble_adder_pkg holds:
//       typedef enum logic [1:0] {IDLE, ADD, DONE} nsa_state_t
//       localparam NIBBLE_W = 4
//   - Sub-module: the existing adder_4bit, instantiated once as the datapath.
//   - The rest is the FSM, shift registers, carry reg and a count of $clog2(NUM_NIBBLES)+1 bits.
//
// TESTING
//   1. WIDTH=16, op_a=16'hFFFF, op_b=16'h0001, carry_in=0 -> after 4 cycles result_valid=1, sum=16'h0000, carry_out=1.
//   2. op_a=16'h1234, op_b=16'h4321, carry_in=1 -> sum=16'h5556, carry_out=0; start_ready=0 throughout ADD and DONE.
//   3. Hold result_ready=0 for 5 cycles in DONE -> sum/carry_out/result_valid stable; start_valid pulses ignored; release -> IDLE next cycle.
//   4. Assert rst on the 2nd ADD cycle -> IDLE with outputs at reset values next cycle; result_valid never asserts.
//   5. WIDTH=4, all 512 {carry_in,op_b,op_a} combinations -> result_valid 1 cycle after start; {carry_out,sum} == op_a+op_b+carry_in.
//   6. Back-to-back: result_ready=1 and start_valid=1 held high -> a new start is accepted every 5 cycles; each result is correct for its own operands.

Source files
------------

// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM state encoding
// and the width of one adder slice.
package nibble_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } nsa_state_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/adder_4bit.sv
// Shared 4-bit ripple datapath: one nibble plus carry in, nibble sum plus carry out.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per cycle (LSB first) through a single
// adder_4bit, with valid/ready handshakes on start and result.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int NUM_NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W       = $clog2(NUM_NIBBLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIBBLES - 1);

    nsa_state_t       state_r;
    nsa_state_t       state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_shift_s;
    logic             carry_r;
    logic             carry_out_r;
    logic [CNT_W-1:0] count_r;
    logic [3:0]       nib_sum_s;
    logic             nib_cout_s;
    logic             last_s;

    adder_4bit u_adder (
        .a    (a_sh_r[3:0]),
        .b    (b_sh_r[3:0]),
        .cin  (carry_r),
        .sum  (nib_sum_s),
        .cout (nib_cout_s)
    );

    // New nibble enters at the top while the partial sum moves down one nibble.
    assign sum_shift_s = WIDTH'({nib_sum_s, sum_r} >> NIBBLE_W);
    assign last_s      = (count_r == LAST_CNT);

    // Next-state decode; unused encodings fall back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ADD;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus operand shifters, carry register, counter and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            count_r     <= '0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        a_sh_r  <= op_a;
                        b_sh_r  <= op_b;
                        carry_r <= carry_in;
                        count_r <= '0;
                    end
                end
                ADD: begin
                    sum_r   <= sum_shift_s;
                    a_sh_r  <= a_sh_r >> NIBBLE_W;
                    b_sh_r  <= b_sh_r >> NIBBLE_W;
                    carry_r <= nib_cout_s;
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        carry_out_r <= nib_cout_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign start_ready  = (state_r == IDLE);
    assign result_valid = (state_r == DONE);
    assign busy         = (state_r == ADD) || (state_r == DONE);
    assign sum          = sum_r;
    assign carry_out    = carry_out_r;

endmodule
